// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg: shared memory-system types and defaults for the SRAM path
package sram_controller_pkg;
  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} sram_state_e;
  localparam int unsigned SRAM_WAIT_CYCLES = 2;
  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter flagging the last cycle of an access phase
module sram_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  output logic       term_o
);
  logic [2:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (cnt_q != 3'd0 ? cnt_q - 3'd1 : 3'd0);
  always_ff @(posedge clk)
    if (rst) cnt_q <= 3'd0;
    else cnt_q <= cnt_d;
  assign term_o = cnt_q == 3'd0;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: 32-bit request port to 16-bit asynchronous SRAM, two halfword phases
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = SRAM_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_r_en,
  input  logic        sram_w_en,
  input  logic [31:0] sram_address,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        sram_ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);
  localparam logic [2:0] RELOAD = 3'(WAIT_CYCLES - 1);
  sram_state_e state_q, state_d;
  logic [16:0] off_q, off_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, diff;
  logic [17:0] addr_q, addr_d;
  logic        wr_q, wr_d, load, term, acc, unused;
  sram_wait_counter u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (RELOAD),
    .term_o     (term)
  );
  assign diff = sram_address - BASE_ADDR;
  assign unused = ^{diff[31:19], diff[1:0]};
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (sram_w_en || sram_r_en) begin
        state_d = ACC_LO;
        off_d   = diff[18:2];
        wdata_d = sram_wdata;
        wr_d    = sram_w_en;
        addr_d  = {diff[18:2], 1'b0};
        load    = 1'b1;
      end
      ACC_LO: if (term) begin
        state_d = ACC_HI;
        addr_d  = {off_q, 1'b1};
        load    = 1'b1;
        rdata_d[15:0] = wr_q ? rdata_q[15:0] : SRAM_DQ;
      end
      ACC_HI: if (term) begin
        state_d = DONE;
        rdata_d[31:16] = wr_q ? rdata_q[31:16] : SRAM_DQ;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      off_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  assign acc        = state_q == ACC_LO || state_q == ACC_HI;
  assign SRAM_WE_N  = !(acc && wr_q);
  assign SRAM_OE_N  = !(acc && !wr_q);
  assign SRAM_DQ    = (acc && wr_q) ? (state_q == ACC_HI ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_CE_N  = 1'b0;
  assign SRAM_UB_N  = 1'b0;
  assign SRAM_LB_N  = 1'b0;
  assign sram_rdata = rdata_q;
  assign sram_ready = state_q == DONE;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed vector table plus corner sequences against an SRAM model
module tb_sram_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst = 1'b1, r_en = 1'b0, w_en = 1'b0, ready, we_n, oe_n, ce_n, ub_n, lb_n;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [17:0] sram_addr;
  wire  [15:0] dq;
  logic        r1_en = 1'b0, ready1, we1_n, oe1_n, ce1_n, ub1_n, lb1_n;
  logic [31:0] addr1 = '0, rdata1;
  logic [17:0] sram_addr1;
  wire  [15:0] dq1;
  logic [15:0] mem [0:262143];
  logic [15:0] mem_rd;
  sram_controller u_dut (
    .clk(clk), .rst(rst), .sram_r_en(r_en), .sram_w_en(w_en), .sram_address(addr),
    .sram_wdata(wdata), .sram_rdata(rdata), .sram_ready(ready), .SRAM_DQ(dq),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );
  sram_controller #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .sram_r_en(r1_en), .sram_w_en(1'b0), .sram_address(addr1),
    .sram_wdata(32'd0), .sram_rdata(rdata1), .sram_ready(ready1), .SRAM_DQ(dq1),
    .SRAM_ADDR(sram_addr1), .SRAM_WE_N(we1_n), .SRAM_OE_N(oe1_n), .SRAM_CE_N(ce1_n),
    .SRAM_UB_N(ub1_n), .SRAM_LB_N(lb1_n)
  );
  assign mem_rd = mem[sram_addr];
  assign dq  = !oe_n ? mem_rd : 16'hzzzz;
  assign dq1 = !oe1_n ? (sram_addr1[15:0] ^ 16'h5A5A) : 16'hzzzz;
  always @(posedge clk) if (!we_n) mem[sram_addr] <= dq;
  int n_vec = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic w; logic r; logic [31:0] a; logic [31:0] wd;
    logic [17:0] alo; logic [31:0] rd; logic [15:0] m_lo; logic [15:0] m_hi;
  } vec_t;
  vec_t tbl [9];
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    logic [17:0] a1, a3;
    logic we1, oe1;
    logic [15:0] d1;
    w_en = v.w; r_en = v.r; addr = v.a; wdata = v.wd;
    step;
    w_en = 1'b0; r_en = 1'b0; addr = 32'hFFFF_FFF0; wdata = 32'h0;
    cyc = 1; a1 = sram_addr; we1 = we_n; oe1 = oe_n; d1 = dq; a3 = '0;
    while (!ready && cyc < 20) begin
      step;
      cyc++;
      if (cyc == 3) a3 = sram_addr;
    end
    chk($sformatf("v%0d latency", idx), cyc, 5);
    chk($sformatf("v%0d addr_lo", idx), a1, v.alo);
    chk($sformatf("v%0d addr_hi", idx), a3, v.alo | 18'd1);
    chk($sformatf("v%0d we_n", idx), we1, v.w ? 1'b0 : 1'b1);
    chk($sformatf("v%0d oe_n", idx), oe1, v.w ? 1'b1 : 1'b0);
    chk($sformatf("v%0d dq_lo", idx), d1, v.m_lo);
    chk($sformatf("v%0d rdata", idx), rdata, v.rd);
    step;
    chk($sformatf("v%0d ready_drop", idx), ready, 1'b0);
    chk($sformatf("v%0d mem_lo", idx), mem[v.alo], v.m_lo);
    chk($sformatf("v%0d mem_hi", idx), mem[v.alo | 18'd1], v.m_hi);
  endtask
  initial begin
    logic [17:0] exp_a [12] = '{0, 0, 1, 1, 1, 1, 2, 2, 3, 3, 3, 3};
    logic        exp_r [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    int seen;
    vec_t post;
    tbl[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'h0,     32'h00000000, 16'hBEEF, 16'hDEAD};
    tbl[1] = '{1'b0, 1'b1, 32'd1024, 32'h0,        18'h0,     32'hDEADBEEF, 16'hBEEF, 16'hDEAD};
    tbl[2] = '{1'b1, 1'b1, 32'd1032, 32'h12345678, 18'h4,     32'hDEADBEEF, 16'h5678, 16'h1234};
    tbl[3] = '{1'b0, 1'b1, 32'd1032, 32'h0,        18'h4,     32'h12345678, 16'h5678, 16'h1234};
    tbl[4] = '{1'b1, 1'b0, 32'd1027, 32'hCAFEF00D, 18'h0,     32'h12345678, 16'hF00D, 16'hCAFE};
    tbl[5] = '{1'b0, 1'b1, 32'd1026, 32'h0,        18'h0,     32'hCAFEF00D, 16'hF00D, 16'hCAFE};
    tbl[6] = '{1'b1, 1'b0, 32'd1020, 32'hA1B2C3D4, 18'h3FFFE, 32'hCAFEF00D, 16'hC3D4, 16'hA1B2};
    tbl[7] = '{1'b0, 1'b1, 32'd1020, 32'h0,        18'h3FFFE, 32'hA1B2C3D4, 16'hC3D4, 16'hA1B2};
    tbl[8] = '{1'b1, 1'b0, 32'd1028, 32'h0BADF00D, 18'h2,     32'hA1B2C3D4, 16'hF00D, 16'h0BAD};
    step;
    step;
    chk("rst ready", ready, 1'b0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst addr", sram_addr, 18'h0);
    chk("rst we_n", we_n, 1'b1);
    chk("rst oe_n", oe_n, 1'b1);
    chk("tied strobes", {ce_n, ub_n, lb_n}, 3'b000);
    rst = 1'b0;
    step;
    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);
    r_en = 1'b1; addr = 32'd1024;
    step;
    addr = 32'd1028;
    for (int c = 1; c <= 12; c++) begin
      if (c == 7) r_en = 1'b0;
      chk($sformatf("b2b addr c%0d", c), sram_addr, exp_a[c-1]);
      chk($sformatf("b2b ready c%0d", c), ready, exp_r[c-1]);
      if (c == 5) chk("b2b rdata first", rdata, 32'hCAFEF00D);
      if (c == 11) chk("b2b rdata second", rdata, 32'h0BADF00D);
      step;
    end
    w_en = 1'b1; addr = 32'd1040; wdata = 32'h55667788;
    step;
    w_en = 1'b0;
    step;
    step;
    chk("abort we_n before", we_n, 1'b0);
    chk("abort addr before", sram_addr, 18'h9);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("abort we_n", we_n, 1'b1);
    chk("abort oe_n", oe_n, 1'b1);
    chk("abort ready", ready, 1'b0);
    chk("abort rdata", rdata, 32'h0);
    chk("abort addr", sram_addr, 18'h0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (ready) seen++;
      step;
    end
    chk("abort no ready", seen, 0);
    chk("abort mem_lo", mem[8], 16'h7788);
    chk("abort mem_hi", mem[9], 16'h5566);
    post = '{1'b0, 1'b1, 32'd1040, 32'h0, 18'h8, 32'h55667788, 16'h7788, 16'h5566};
    run_vec(post, 9);
    r1_en = 1'b1; addr1 = 32'd1020;
    step;
    r1_en = 1'b0;
    chk("w1 addr_lo", sram_addr1, 18'h3FFFE);
    chk("w1 oe_n", oe1_n, 1'b0);
    chk("w1 ready c1", ready1, 1'b0);
    step;
    chk("w1 addr_hi", sram_addr1, 18'h3FFFF);
    chk("w1 ready c2", ready1, 1'b0);
    step;
    chk("w1 ready c3", ready1, 1'b1);
    chk("w1 rdata", rdata1, 32'hA5A5A5A4);
    step;
    chk("w1 ready drop", ready1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
